// File: rtl/float_accumulate_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module      : float_accumulate_sequencer_if
// Description : Bus bundle for float_accumulate_sequencer. Groups the operand
//               stream (In*), the FloatAdder issue/result handshake (Add*) and
//               the group-sum output handshake (Sum*).
// Modports    : master - the sequencer (drives InReady, Add*, Sum, SumValid)
//               slave  - the environment (producer, FloatAdder, consumer)
// Signals     : InData[31:0], InLast, InValid, InReady
//               AddOp1[31:0], AddOp2[31:0], AddInputValid
//               AddResult[31:0], AddResultValid
//               Sum[31:0], SumValid, SumReady
// Revision    : 1.0 - initial release
//==============================================================================
interface float_accumulate_sequencer_if;
   logic [31:0] InData;
   logic        InLast;
   logic        InValid;
   logic        InReady;
   logic [31:0] AddOp1;
   logic [31:0] AddOp2;
   logic        AddInputValid;
   logic [31:0] AddResult;
   logic        AddResultValid;
   logic [31:0] Sum;
   logic        SumValid;
   logic        SumReady;

   modport master (
      input  InData, InLast, InValid,
      output InReady,
      output AddOp1, AddOp2, AddInputValid,
      input  AddResult, AddResultValid,
      output Sum, SumValid,
      input  SumReady
   );

   modport slave (
      output InData, InLast, InValid,
      input  InReady,
      input  AddOp1, AddOp2, AddInputValid,
      output AddResult, AddResultValid,
      input  Sum, SumValid,
      output SumReady
   );
endinterface
`default_nettype wire

// File: rtl/float_accumulate_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : float_accumulate_sequencer
// Description : Issuing side of the FloatAdder InputValid/ResultValid
//               handshake. Buffers single-precision operands in a small FIFO,
//               issues one addition at a time with the running sum as Op1,
//               feeds each result back into the accumulator and presents one
//               Sum per InLast-terminated group.
// Parameters  : FIFO_DEPTH     - operand buffer entries (>=2)
//               TIMEOUT_CYCLES - WAIT cycles before an adder op is abandoned
// Ports       : Clock, Reset (sync, active-high), Clear (sync flush)
//               bus     - float_accumulate_sequencer_if.master
//               Busy    - FSM not idle or FIFO non-empty
//               Timeout - sticky, an adder op was abandoned
// Macro       : FACC_SKIP_ZERO_EN - when defined, non-first +/-0 operands are
//               consumed in IDLE without issuing an adder op.
// Revision    : 1.0 - initial release
//==============================================================================
module float_accumulate_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  wire logic                    Clock,
   input  wire logic                    Reset,
   input  wire logic                    Clear,
   float_accumulate_sequencer_if.master bus,
   output logic                         Busy,
   output logic                         Timeout
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_OUTPUT = 2'd3
   } state_t;

   state_t state, state_next;

   // Operand FIFO: bit 32 carries InLast alongside the operand.
   logic [32:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic [31:0]       head_data;
   logic              head_last;
   logic              head_zero;
   logic              in_ready;
   logic              push;

   logic [31:0]       acc;
   logic [31:0]       op1, op2;
   logic              first;       // next popped operand starts a new group
   logic              pend_last;   // issued operand closes its group
   logic [WAIT_W-1:0] wait_count;
   logic              timeout_flag;

   // FSM strobes
   logic pop, load_first, skip_op, issue_op, take_result, timeout_hit, sum_fire;

   assign head_data = fifo_mem[rd_ptr][31:0];
   assign head_last = fifo_mem[rd_ptr][32];

`ifdef FACC_SKIP_ZERO_EN
   assign head_zero = (head_data[30:0] == 31'd0);
`else
   assign head_zero = 1'b0;
`endif

   // Gated by Reset/Clear so a push can never slip in during a flush.
   assign in_ready = (fifo_count < CNT_FULL) && !Reset && !Clear;
   assign push     = bus.InValid && in_ready;

   assign bus.InReady       = in_ready;
   assign bus.AddOp1        = op1;
   assign bus.AddOp2        = op2;
   assign bus.AddInputValid = (state == S_ISSUE);
   assign bus.Sum           = acc;
   assign bus.SumValid      = (state == S_OUTPUT);
   assign Busy              = (state != S_IDLE) || (fifo_count != '0);
   assign Timeout           = timeout_flag;

   always_ff @(posedge Clock) begin
      if (Reset || Clear) state <= S_IDLE;
      else                state <= state_next;
   end

   always_comb begin
      state_next  = state;
      pop         = 1'b0;
      load_first  = 1'b0;
      skip_op     = 1'b0;
      issue_op    = 1'b0;
      take_result = 1'b0;
      timeout_hit = 1'b0;
      sum_fire    = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_count != '0) begin
               pop = 1'b1;
               if (first) begin
                  // Group opener goes straight into the accumulator.
                  load_first = 1'b1;
                  state_next = head_last ? S_OUTPUT : S_IDLE;
               end else if (head_zero) begin
                  skip_op    = 1'b1;
                  state_next = head_last ? S_OUTPUT : S_IDLE;
               end else begin
                  issue_op   = 1'b1;
                  state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_next = S_WAIT;
         S_WAIT: begin
            // The adder's ResultValid is still stale on the first WAIT
            // cycle (wait_count == 0), so it is only trusted afterwards.
            if ((wait_count != '0) && bus.AddResultValid) begin
               take_result = 1'b1;
               state_next  = pend_last ? S_OUTPUT : S_IDLE;
            end else if (wait_count == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = pend_last ? S_OUTPUT : S_IDLE;
            end
         end
         S_OUTPUT: begin
            if (bus.SumReady) begin
               sum_fire   = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (push) fifo_mem[wr_ptr] <= {bus.InLast, bus.InData};
   end

   always_ff @(posedge Clock) begin
      if (Reset || Clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         acc          <= 32'h0;
         op1          <= 32'h0;
         op2          <= 32'h0;
         first        <= 1'b1;
         pend_last    <= 1'b0;
         wait_count   <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         fifo_count <= fifo_count + {{(CNT_W-1){1'b0}}, push}
                                  - {{(CNT_W-1){1'b0}}, pop};

         if (load_first) begin
            acc   <= head_data;
            first <= head_last;
         end
         if (skip_op) first <= head_last;
         if (issue_op) begin
            op1       <= acc;
            op2       <= head_data;
            pend_last <= head_last;
         end

         if (state == S_ISSUE)     wait_count <= '0;
         else if (state == S_WAIT) wait_count <= wait_count + 1'b1;

         if (take_result) acc <= bus.AddResult;
         if (take_result || timeout_hit) first <= pend_last;
         if (timeout_hit) timeout_flag <= 1'b1;
         if (sum_fire)    acc <= 32'h0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_float_accumulate_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_float_accumulate_sequencer
// Description : Self-checking bench for float_accumulate_sequencer with a
//               behavioural FloatAdder model and a group-sum reference model.
//               Optional macro FACC_SKIP_ZERO_EN changes the expected op count.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_float_accumulate_sequencer;
   localparam int DEPTH = 4;
   localparam int TMO   = 64;

   logic Clock = 1'b0;
   logic Reset, Clear;
   logic Busy, Timeout;

   float_accumulate_sequencer_if bus();

   float_accumulate_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Clear   (Clear),
      .bus     (bus),
      .Busy    (Busy),
      .Timeout (Timeout)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   logic [31:0] sum_q[$];
   int add_ops = 0;
   bit adder_hang = 1'b0;
   bit rand_lat   = 1'b0;
   bit rand_ready = 1'b0;

   // Floats handled as fixed point with 8 fractional bits; all test values
   // are small and exactly representable, so sums are exact.
   function automatic longint sp_to_fix(input logic [31:0] b);
      int e;
      longint m, v;
      if (b[30:0] == 31'd0) return 0;
      e = int'(b[30:23]) - 127;
      m = longint'({1'b1, b[22:0]});
      if (e >= 15) v = m <<< (e - 15);
      else         v = m >>> (15 - e);
      return b[31] ? -v : v;
   endfunction

   function automatic logic [31:0] fix_to_sp(input longint f);
      logic   s;
      longint a, m;
      int     p;
      if (f == 0) return 32'h0;
      s = (f < 0);
      a = s ? -f : f;
      p = 0;
      for (int i = 0; i < 62; i++) if (a[i]) p = i;
      m = (p >= 23) ? (a >>> (p - 23)) : (a <<< (23 - p));
      return {s, 8'(p + 119), m[22:0]};
   endfunction

   // FloatAdder model: ResultValid is a level that drops one cycle after
   // InputValid and rises again with the sum after the latency.
   int          a_cnt, a_lat;
   bit          a_busy;
   logic [31:0] a_op1, a_op2;
   always @(posedge Clock) begin
      if (Reset) begin
         bus.AddResultValid <= 1'b0;
         bus.AddResult      <= 32'h0;
         a_busy <= 1'b0;
         a_cnt  <= 0;
         a_lat  <= 4;
      end else if (bus.AddInputValid) begin
         a_op1  <= bus.AddOp1;
         a_op2  <= bus.AddOp2;
         a_busy <= 1'b1;
         a_cnt  <= 1;
         a_lat  <= rand_lat ? int'($urandom_range(2, 6)) : 4;
      end else if (a_busy) begin
         if (a_cnt == 1) bus.AddResultValid <= 1'b0;
         if (a_cnt >= a_lat && !adder_hang) begin
            bus.AddResult      <= fix_to_sp(sp_to_fix(a_op1) + sp_to_fix(a_op2));
            bus.AddResultValid <= 1'b1;
            a_busy             <= 1'b0;
         end
         a_cnt <= a_cnt + 1;
      end
   end

   always @(posedge Clock) begin
      if (!Reset && !Clear) begin
         if (bus.SumValid && bus.SumReady) sum_q.push_back(bus.Sum);
         if (bus.AddInputValid) add_ops++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      int n = 0;
      @(negedge Clock);
      bus.InData  = d;
      bus.InLast  = last;
      bus.InValid = 1'b1;
      while (!bus.InReady && n < 1000) begin
         if (rand_ready) bus.SumReady = 1'($urandom_range(0, 1));
         @(negedge Clock);
         n++;
      end
      if (!bus.InReady) begin
         check("send_budget", 32'(bus.InReady), 32'd1);
      end else begin
         @(posedge Clock);
      end
      #1 bus.InValid = 1'b0;
   endtask

   task automatic wait_sums(input int n);
      int k = 0;
      while (sum_q.size() < n && k < 3000) begin
         @(negedge Clock);
         if (rand_ready) bus.SumReady = 1'($urandom_range(0, 1));
         k++;
      end
      if (sum_q.size() < n) check("wait_sums", 32'(sum_q.size()), 32'(n));
   endtask

   task automatic wait_sumvalid();
      int k = 0;
      while (!bus.SumValid && k < 500) begin
         @(negedge Clock);
         k++;
      end
      if (!bus.SumValid) check("wait_sumvalid", 32'(bus.SumValid), 32'd1);
   endtask

   task automatic wait_issue();
      int k = 0;
      @(negedge Clock);
      while (!bus.AddInputValid && k < 100) begin
         @(negedge Clock);
         k++;
      end
      if (!bus.AddInputValid) check("wait_issue", 32'(bus.AddInputValid), 32'd1);
   endtask

   function automatic logic [31:0] pop_sum();
      if (sum_q.size() == 0) return 32'hDEADBEEF;
      return sum_q.pop_front();
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ops0, k, exp_ops, len, v, total;
      logic [31:0] exp_sums[$];

      Reset = 1'b1;
      Clear = 1'b0;
      bus.InData   = 32'h0;
      bus.InLast   = 1'b0;
      bus.InValid  = 1'b0;
      bus.SumReady = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check("rst_InReady",       32'(bus.InReady),       32'd0);
      check("rst_SumValid",      32'(bus.SumValid),      32'd0);
      check("rst_AddInputValid", 32'(bus.AddInputValid), 32'd0);
      check("rst_Sum",           bus.Sum,                32'h0);
      check("rst_AddOp1",        bus.AddOp1,             32'h0);
      check("rst_Busy",          32'(Busy),              32'd0);
      check("rst_Timeout",       32'(Timeout),           32'd0);
      Reset = 1'b0;
      @(negedge Clock);
      check("idle_InReady", 32'(bus.InReady), 32'd1);

      // Three-operand group: 1.0 + 2.0 + 0.5
      ops0 = add_ops;
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b0);
      send(32'h3F000000, 1'b1);
      wait_sumvalid();
      check("t1_sum", bus.Sum, 32'h40600000);
      check("t1_ops", 32'(add_ops - ops0), 32'd2);
      repeat (3) @(negedge Clock);
      check("t1_hold_valid", 32'(bus.SumValid), 32'd1);
      check("t1_hold_sum",   bus.Sum,           32'h40600000);
      bus.SumReady = 1'b1;
      @(posedge Clock);
      #1;
      check("t1_release", 32'(bus.SumValid), 32'd0);
      wait_sums(1);
      check("t1_q", pop_sum(), 32'h40600000);

      // Single-element group needs no adder op
      ops0 = add_ops;
      send(32'h40400000, 1'b1);
      wait_sums(1);
      check("t2_sum", pop_sum(), 32'h40400000);
      check("t2_ops", 32'(add_ops - ops0), 32'd0);

      // Back-pressure on Sum fills the FIFO without losing data
      @(negedge Clock);
      bus.SumReady = 1'b0;
      send(32'h3F800000, 1'b1);
      wait_sumvalid();
      send(32'h40000000, 1'b0);
      send(32'h40400000, 1'b0);
      send(32'h40800000, 1'b1);
      send(32'h40A00000, 1'b1);
      check("t3_full", 32'(bus.InReady), 32'd0);
      repeat (20) @(negedge Clock);
      check("t3_stable_sum",   bus.Sum,           32'h3F800000);
      check("t3_stable_valid", 32'(bus.SumValid), 32'd1);
      check("t3_still_full",   32'(bus.InReady),  32'd0);
      bus.SumReady = 1'b1;
      wait_sums(3);
      check("t3_sum0", pop_sum(), 32'h3F800000);
      check("t3_sum1", pop_sum(), 32'h41100000);
      check("t3_sum2", pop_sum(), 32'h40A00000);

      // Adder never answers: op abandoned after TMO WAIT cycles
      adder_hang = 1'b1;
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b1);
      wait_issue();
      k = 0;
      while (!Timeout && k < 200) begin
         @(negedge Clock);
         k++;
      end
      check("t4_latency", 32'(k), 32'(TMO + 1));
      wait_sums(1);
      check("t4_sum", pop_sum(), 32'h3F800000);
      check("t4_sticky", 32'(Timeout), 32'd1);
      adder_hang = 1'b0;
      @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
      Clear = 1'b0;
      check("t4_clear", 32'(Timeout), 32'd0);

      // Clear while waiting on the adder; late result must be ignored
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b1);
      wait_issue();
      repeat (2) @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
      Clear = 1'b0;
      check("t5_busy", 32'(Busy), 32'd0);
      repeat (8) @(negedge Clock);
      check("t5_no_sum", 32'(sum_q.size()) | 32'(bus.SumValid), 32'd0);
      send(32'h40000000, 1'b1);
      wait_sums(1);
      check("t5_sum", pop_sum(), 32'h40000000);
      send(32'h40400000, 1'b0);
      send(32'h40800000, 1'b1);
      wait_sums(1);
      check("t5_rearm", pop_sum(), 32'h40E00000);

      // Signed zeros after the group opener
      ops0 = add_ops;
      send(32'h3F800000, 1'b0);
      send(32'h00000000, 1'b0);
      send(32'h80000000, 1'b1);
      wait_sums(1);
      check("t6_sum", pop_sum(), 32'h3F800000);
`ifdef FACC_SKIP_ZERO_EN
      check("t6_ops", 32'(add_ops - ops0), 32'd0);
`else
      check("t6_ops", 32'(add_ops - ops0), 32'd2);
`endif

      // Randomized groups against the reference model
      rand_lat   = 1'b1;
      rand_ready = 1'b1;
      ops0    = add_ops;
      exp_ops = 0;
      for (int g = 0; g < 20; g++) begin
         len   = int'($urandom_range(1, 4));
         total = 0;
         for (int i = 0; i < len; i++) begin
            v = int'($urandom_range(1, 60));
            total += v;
            send(fix_to_sp(longint'(v) * 256), (i == len - 1));
         end
         exp_sums.push_back(fix_to_sp(longint'(total) * 256));
         exp_ops += len - 1;
      end
      rand_ready = 1'b0;
      @(negedge Clock);
      bus.SumReady = 1'b1;
      wait_sums(20);
      for (int g = 0; g < 20; g++) begin
         check($sformatf("rnd_sum%0d", g), pop_sum(), exp_sums[g]);
      end
      check("rnd_ops", 32'(add_ops - ops0), 32'(exp_ops));
      repeat (4) @(negedge Clock);
      check("end_busy",  32'(Busy),         32'd0);
      check("end_extra", 32'(sum_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
